store_merge_unit: RTL

- Write-side counterpart to the load-path extenders: takes a 32-bit register value plus a store size (SB/SH/SW) and commits it to word-only data memory.
- Byte and halfword stores use a read-modify-write sequence.
- Sits between the multi-cycle datapath's MEM stage and the data memory port, and handles the memory handshake.
- Memory is big-endian, matching the MIPS target.

---
 rtl/store_merge_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit: commits SB/SH/SW stores to a word-only data memory.
// Sub-word stores do a read-modify-write. Word stores write directly.
// Every output is a flop, so the memory port sees no combinational paths.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; request fields latched on acceptance
// S_READ  | mem_rd_en high until mem_rvalid; old word merged with store data
// S_WRITE | mem_wr_en high with merged word until mem_wready
// S_DONE  | one-cycle done pulse after a successful store
// S_ERR   | one-cycle done + misalign_err pulse; memory never touched
module store_merge_unit #(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        off_q, off_d;
    logic              half_q, half_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;

    logic              illegal;
    logic [1:0]        lane;
    logic              half_upper;
    logic [31:0]       merged;

    // Request legality: size 11 is never valid, halves need even, words need 4-byte alignment.
    always_comb begin
        illegal = (size == 2'b11)
               || ((size == 2'b01) && addr[0])
               || ((size == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Merge latched store data into the word returned by the read.
    always_comb begin
        merged     = mem_rdata;
        lane       = (BIG_ENDIAN != 0) ? (2'd3 - off_q) : off_q;
        half_upper = (BIG_ENDIAN != 0) ? ~off_q[1] : off_q[1];
        if (half_q) begin
            if (half_upper) merged[31:16] = wdata_q;
            else            merged[15:0]  = wdata_q;
        end else begin
            merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        half_d      = half_q;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d     = 1'b1;
                    mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    off_d      = addr[1:0];
                    half_d     = (size == 2'b01);
                    wdata_d    = wdata[15:0];
                    if (illegal) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (size == 2'b10) begin
                        state_d     = S_WRITE;
                        wr_en_d     = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = S_READ;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (mem_rvalid) begin
                    state_d     = S_WRITE;
                    wr_en_d     = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (mem_wready) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wdata_q     <= '0;
            off_q       <= '0;
            half_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            half_q      <= half_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign misalign_err = err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
